// File: rtl/vent_pkg.sv
// Shared ventilation types: per-zone FSM state encoding and its width.
package vent_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ZS_IDLE   = 2'd0,
        ZS_ARMING = 2'd1,
        ZS_ON     = 2'd2,
        ZS_HOLD   = 2'd3
    } zone_state_e;

endpackage

// File: rtl/vent_zone_fsm.sv
// One ventilation zone: sensor synchroniser, on-debounce / off-hold FSM,
// counter and registered fan enable. fan_nxt exposes the value fan_on takes
// at the next edge so the top can register its summary in the same cycle.
import vent_pkg::*;

module vent_zone_fsm #(
    parameter int CNT_W       = 4,
    parameter int ON_THRESH   = 3,
    parameter int OFF_HOLD    = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sensor,
    output logic [STATE_W-1:0] state,
    output logic [CNT_W-1:0]   cnt,
    output logic               fan_on,
    output logic               fan_nxt
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    zone_state_e            state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   fan_q, fan_d;
    logic                   s;

    // Synchroniser shift: new raw sample enters stage 0.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], sensor};
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Next-state logic; counters are bounded by the thresholds and never wrap.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ZS_IDLE: begin
                cnt_d = '0;
                if (s) begin
                    state_d = ZS_ARMING;
                    cnt_d   = CNT_W'(1);
                end
            end
            ZS_ARMING: begin
                if (!s) begin
                    state_d = ZS_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q + CNT_W'(1) == CNT_W'(ON_THRESH)) begin
                    state_d = ZS_ON;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            ZS_ON: begin
                cnt_d = '0;
                if (!s) begin
                    state_d = ZS_HOLD;
                    cnt_d   = CNT_W'(1);
                end
            end
            ZS_HOLD: begin
                if (s) begin
                    state_d = ZS_ON;
                    cnt_d   = '0;
                end else if (cnt_q + CNT_W'(1) == CNT_W'(OFF_HOLD)) begin
                    state_d = ZS_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ZS_IDLE;
                cnt_d   = '0;
            end
        endcase
        fan_d = (state_d == ZS_ON) || (state_d == ZS_HOLD);
    end

    // State, counter, fan and synchroniser registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            state_q <= ZS_IDLE;
            cnt_q   <= '0;
            fan_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fan_q   <= fan_d;
        end
    end

    assign state   = state_q;
    assign cnt     = cnt_q;
    assign fan_on  = fan_q;
    assign fan_nxt = fan_d;

endmodule

// File: rtl/vent_zone_ctrl.sv
// Multi-zone ventilation controller: NUM_ZONES independent zone FSMs plus a
// registered count of running fans and an any-fan-on flag.
// Optional manual override per zone enabled by defining VENT_FORCE_EN.
import vent_pkg::*;

module vent_zone_ctrl #(
    parameter int NUM_ZONES   = 4,
    parameter int CNT_W       = 4,
    parameter int ON_THRESH   = 3,
    parameter int OFF_HOLD    = 8,
    parameter int SYNC_STAGES = 2,
    localparam int AC_W       = $clog2(NUM_ZONES + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_ZONES-1:0]         sensor,
`ifdef VENT_FORCE_EN
    input  logic [NUM_ZONES-1:0]         force_on,
`endif
    output logic [NUM_ZONES-1:0]         fan_on,
    output logic [STATE_W*NUM_ZONES-1:0] zone_state,
    output logic [CNT_W*NUM_ZONES-1:0]   zone_cnt,
    output logic [AC_W-1:0]              active_count,
    output logic                         any_on
);

    logic [NUM_ZONES-1:0] fsm_fan;
    logic [NUM_ZONES-1:0] fsm_fan_nxt;
    logic [NUM_ZONES-1:0] fan_nxt;
    logic [AC_W-1:0]      active_count_q, active_count_d;
    logic                 any_on_q, any_on_d;

    for (genvar z = 0; z < NUM_ZONES; z++) begin : g_zone
        vent_zone_fsm #(
            .CNT_W       (CNT_W),
            .ON_THRESH   (ON_THRESH),
            .OFF_HOLD    (OFF_HOLD),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_zone (
            .clk     (clk),
            .rst     (rst),
            .sensor  (sensor[z]),
            .state   (zone_state[STATE_W*z +: STATE_W]),
            .cnt     (zone_cnt[CNT_W*z +: CNT_W]),
            .fan_on  (fsm_fan[z]),
            .fan_nxt (fsm_fan_nxt[z])
        );
    end

`ifdef VENT_FORCE_EN
    logic [SYNC_STAGES-1:0][NUM_ZONES-1:0] force_sync_q, force_sync_d;

    // Override synchroniser; stage 0 takes the raw request.
    always_comb begin
        force_sync_d = {force_sync_q[SYNC_STAGES-2:0], force_on};
    end

    // Override synchroniser registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) force_sync_q <= '0;
        else     force_sync_q <= force_sync_d;
    end

    // Next-edge fan value includes the override stage about to become visible.
    assign fan_nxt = fsm_fan_nxt | force_sync_q[SYNC_STAGES-2];
    assign fan_on  = fsm_fan     | force_sync_q[SYNC_STAGES-1];
`else
    assign fan_nxt = fsm_fan_nxt;
    assign fan_on  = fsm_fan;
`endif

    // Summary from next-state fan values so it lines up with fan_on.
    always_comb begin
        active_count_d = '0;
        for (int z = 0; z < NUM_ZONES; z++) begin
            active_count_d = active_count_d + AC_W'(fan_nxt[z]);
        end
        any_on_d = |fan_nxt;
    end

    // Summary registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_count_q <= '0;
            any_on_q       <= 1'b0;
        end else begin
            active_count_q <= active_count_d;
            any_on_q       <= any_on_d;
        end
    end

    assign active_count = active_count_q;
    assign any_on       = any_on_q;

endmodule

// File: tb/tb_vent_zone_ctrl.sv
// Self-checking bench for vent_zone_ctrl: directed latency/glitch scenarios
// followed by randomized sensor (and override) traffic against a run-length
// reference model of each zone.
import vent_pkg::*;

module tb_vent_zone_ctrl;

    localparam int NZ   = 4;
    localparam int CW   = 4;
    localparam int ONT  = 3;
    localparam int OFFH = 8;
    localparam int SS   = 2;
    localparam int ACW  = $clog2(NZ + 1);

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NZ-1:0]   sensor_r = '0;
    logic [NZ-1:0]   force_r  = '0;
    logic [NZ-1:0]   fan_on;
    logic [2*NZ-1:0] zone_state;
    logic [CW*NZ-1:0] zone_cnt;
    logic [ACW-1:0]  active_count;
    logic            any_on;

    int n_chk = 0;
    int n_err = 0;

    vent_zone_ctrl #(
        .NUM_ZONES(NZ), .CNT_W(CW), .ON_THRESH(ONT), .OFF_HOLD(OFFH), .SYNC_STAGES(SS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sensor       (sensor_r),
`ifdef VENT_FORCE_EN
        .force_on     (force_r),
`endif
        .fan_on       (fan_on),
        .zone_state   (zone_state),
        .zone_cnt     (zone_cnt),
        .active_count (active_count),
        .any_on       (any_on)
    );

    always #5 clk = ~clk;

    // Reference model: each zone is "off" or "on" plus the length of the
    // current qualifying run of synced highs (while off) or lows (while on).
    logic [NZ-1:0] shist [SS];
    logic [NZ-1:0] fhist [SS];
    bit            m_fan [NZ];
    int            m_run [NZ];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < SS; i++) begin
            shist[i] = '0;
            fhist[i] = '0;
        end
        for (int z = 0; z < NZ; z++) begin
            m_fan[z] = 0;
            m_run[z] = 0;
        end
    endtask

    task automatic model_step();
        logic [NZ-1:0] s;
        s = shist[SS-1];
        for (int i = SS-1; i > 0; i--) begin
            shist[i] = shist[i-1];
            fhist[i] = fhist[i-1];
        end
        shist[0] = sensor_r;
`ifdef VENT_FORCE_EN
        fhist[0] = force_r;
`else
        fhist[0] = '0;
`endif
        for (int z = 0; z < NZ; z++) begin
            if (!m_fan[z]) begin
                if (s[z]) begin
                    m_run[z]++;
                    if (m_run[z] == ONT) begin
                        m_fan[z] = 1;
                        m_run[z] = 0;
                    end
                end else m_run[z] = 0;
            end else begin
                if (!s[z]) begin
                    m_run[z]++;
                    if (m_run[z] == OFFH) begin
                        m_fan[z] = 0;
                        m_run[z] = 0;
                    end
                end else m_run[z] = 0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [NZ-1:0]    e_fan;
        logic [2*NZ-1:0]  e_st;
        logic [CW*NZ-1:0] e_cnt;
        for (int z = 0; z < NZ; z++) begin
            e_fan[z] = m_fan[z] | fhist[SS-1][z];
            if (m_fan[z]) e_st[2*z +: 2] = (m_run[z] > 0) ? 2'd3 : 2'd2;
            else          e_st[2*z +: 2] = (m_run[z] > 0) ? 2'd1 : 2'd0;
            e_cnt[CW*z +: CW] = CW'(m_run[z]);
        end
        chk({tag, ".fan_on"},       32'(fan_on),       32'(e_fan));
        chk({tag, ".zone_state"},   32'(zone_state),   32'(e_st));
        chk({tag, ".zone_cnt"},     32'(zone_cnt),     32'(e_cnt));
        chk({tag, ".active_count"}, 32'(active_count), 32'($countones(e_fan)));
        chk({tag, ".any_on"},       32'(any_on),       32'(|e_fan));
    endtask

    // One clock edge: advance the model with the inputs that were set up
    // before the edge, then compare 1 time unit later.
    task automatic tick(input string tag);
        @(posedge clk);
        if (rst) model_reset();
        else     model_step();
        #1 check_all(tag);
    endtask

    task automatic async_reset(input string tag);
        rst = 1'b1;
        model_reset();
        #1 check_all(tag);
    endtask

    initial begin
        logic [NZ-1:0] flip;
        int            pdiv;

        // 1: reset with active sensors, then idle.
        model_reset();
        sensor_r = 4'b1011;
        #2 check_all("rst_hold");
        repeat (3) tick("rst_clk");
        rst = 1'b0;
        sensor_r = '0;
        repeat (20) tick("idle");

        // 2: zone 0 on-latency.
        sensor_r = 4'b0001;
        for (int e = 1; e <= 6; e++) begin
            tick($sformatf("on_e%0d", e));
            if (e == 3) chk("on_arming_e3", 32'(zone_state[1:0]), 32'(ZS_ARMING));
            if (e == 4) chk("on_fan_low_e4", 32'(fan_on[0]), 32'd0);
            if (e == 5) begin
                chk("on_fan_e5", 32'(fan_on[0]), 32'd1);
                chk("on_count_e5", 32'(active_count), 32'd1);
                chk("on_any_e5", 32'(any_on), 32'd1);
            end
        end

        // 3: zone 0 off-hold latency.
        sensor_r = '0;
        for (int e = 1; e <= 11; e++) begin
            tick($sformatf("off_e%0d", e));
            if (e == 3) begin
                chk("off_hold_e3", 32'(zone_state[1:0]), 32'(ZS_HOLD));
                chk("off_cnt_e3", 32'(zone_cnt[3:0]), 32'd1);
            end
            if (e == 9)  chk("off_fan_e9", 32'(fan_on[0]), 32'd1);
            if (e == 10) chk("off_fan_e10", 32'(fan_on[0]), 32'd0);
        end

        // 4a: zone 1 arming glitch restarts qualification.
        for (int e = 1; e <= 9; e++) begin
            sensor_r = (e == 3) ? 4'b0000 : 4'b0010;
            tick($sformatf("arm_glitch_e%0d", e));
            if (e == 5) chk("arm_glitch_idle", 32'(zone_state[3:2]), 32'(ZS_IDLE));
            if (e == 7) chk("arm_glitch_nofan", 32'(fan_on[1]), 32'd0);
            if (e == 8) chk("arm_glitch_fan", 32'(fan_on[1]), 32'd1);
        end

        // 4b: one high sample during hold cancels it.
        for (int e = 1; e <= 7; e++) begin
            sensor_r = (e == 4) ? 4'b0010 : 4'b0000;
            tick($sformatf("hold_glitch_e%0d", e));
            if (e == 5) chk("hold_glitch_cnt3", 32'(zone_cnt[7:4]), 32'd3);
            if (e == 6) begin
                chk("hold_glitch_on", 32'(zone_state[3:2]), 32'(ZS_ON));
                chk("hold_glitch_cnt0", 32'(zone_cnt[7:4]), 32'd0);
            end
        end
        sensor_r = '0;
        repeat (12) tick("drain");

        // 5: all zones together, then async reset mid-run.
        sensor_r = 4'b1111;
        for (int e = 1; e <= 6; e++) begin
            tick($sformatf("all_e%0d", e));
            if (e == 4) chk("all_fan_e4", 32'(fan_on), 32'h0);
            if (e == 5) begin
                chk("all_fan_e5", 32'(fan_on), 32'hF);
                chk("all_count_e5", 32'(active_count), 32'd4);
            end
        end
        async_reset("mid_rst");
        chk("mid_rst_fan", 32'(fan_on), 32'h0);
        chk("mid_rst_count", 32'(active_count), 32'h0);
        tick("mid_rst_clk");
        rst = 1'b0;
        sensor_r = '0;
        repeat (4) tick("post_rst");

`ifdef VENT_FORCE_EN
        // 6: override on zone 3 with no sensor activity.
        force_r = 4'b1000;
        tick("force_e1");
        chk("force_fan_e1", 32'(fan_on), 32'h0);
        tick("force_e2");
        chk("force_fan_e2", 32'(fan_on), 32'h8);
        chk("force_state_e2", 32'(zone_state[7:6]), 32'(ZS_IDLE));
        chk("force_count_e2", 32'(active_count), 32'd1);
        force_r = '0;
        repeat (3) tick("force_off");
`endif

        // Randomized traffic with varying toggle rates and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            pdiv = (c < 1000) ? 2 : ((c < 2000) ? 8 : 20);
            for (int z = 0; z < NZ; z++) flip[z] = ($urandom_range(pdiv - 1) == 0);
            sensor_r = sensor_r ^ flip;
`ifdef VENT_FORCE_EN
            if ($urandom_range(15) == 0) force_r = NZ'($urandom);
`endif
            if ($urandom_range(499) == 0) begin
                async_reset("rnd_rst");
                tick("rnd_rst_clk");
                rst = 1'b0;
            end
            tick("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
